serial_sub6: RTL and testbench



---
 rtl/serial_sub6.sv | 133 +++++++++++++
 tb/tb_serial_sub6.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub6.sv
// Bit-serial 6-bit subtractor y = s - {0,x}, LSB first, with a start/busy/done handshake.
// Optional SERIAL_SUB_RANGE_EN adds ovf = neg | y[5] (result is not a valid 5-bit addend).
module serial_sub6 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] s,
  input  logic [4:0] x,
  output logic       busy,
  output logic       done,
  output logic [5:0] y,
  output logic       neg
`ifdef SERIAL_SUB_RANGE_EN
  ,
  output logic       ovf
`endif
);

  localparam int unsigned W  = 6;
  localparam int unsigned XW = 5;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_sa, w_sa_nxt;
  logic [W-1:0]    r_sb, w_sb_nxt;
  logic [W-1:0]    r_acc, w_acc_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_borrow, w_borrow_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [W-1:0]    r_y, w_y_nxt;
  logic            r_neg, w_neg_nxt;
  logic            w_d;
  logic            w_bout;
  logic [W-1:0]    w_acc_sh;

  // Full-subtractor cell for the current bit pair
  assign w_d      = r_sa[0] ^ r_sb[0] ^ r_borrow;
  assign w_bout   = (~r_sa[0] & r_sb[0]) | (~r_sa[0] & r_borrow) | (r_sb[0] & r_borrow);
  assign w_acc_sh = {w_d, r_acc[W-1:1]};

  always_comb begin
    w_state_nxt  = r_state;
    w_sa_nxt     = r_sa;
    w_sb_nxt     = r_sb;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_borrow_nxt = r_borrow;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_y_nxt      = r_y;
    w_neg_nxt    = r_neg;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (start) begin
          w_state_nxt  = SHIFT;
          w_sa_nxt     = s;
          w_sb_nxt     = {1'b0, x[XW-1:0]};
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_borrow_nxt = 1'b0;
          w_busy_nxt   = 1'b1;
        end
      end
      SHIFT: begin
        w_sa_nxt     = {1'b0, r_sa[W-1:1]};
        w_sb_nxt     = {1'b0, r_sb[W-1:1]};
        w_acc_nxt    = w_acc_sh;
        w_borrow_nxt = w_bout;
        w_cnt_nxt    = r_cnt + CW'(1);
        w_busy_nxt   = 1'b1;
        if (r_cnt == CW'(W - 1)) begin
          // Last bit: publish result together with the final borrow
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_y_nxt     = w_acc_sh;
          w_neg_nxt   = w_bout;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_y      <= '0;
      r_neg    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sa     <= w_sa_nxt;
      r_sb     <= w_sb_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_borrow <= w_borrow_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_y      <= w_y_nxt;
      r_neg    <= w_neg_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign y    = r_y;
  assign neg  = r_neg;

`ifdef SERIAL_SUB_RANGE_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_neg_nxt | w_y_nxt[W-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub6.sv
// Directed self-checking bench for serial_sub6: handshake timing, arithmetic,
// ignored start during SHIFT, back-to-back start, mid-operation reset, exhaustive recovery.
module tb_serial_sub6;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] s;
  logic [4:0] x;
  logic       busy;
  logic       done;
  logic [5:0] y;
  logic       neg;
`ifdef SERIAL_SUB_RANGE_EN
  logic       ovf;
`endif

  int n_checks;
  int n_errors;
  logic [5:0] last_y;
  logic       last_neg;

  serial_sub6 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .s     (s),
    .x     (x),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .neg   (neg)
`ifdef SERIAL_SUB_RANGE_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [5:0] ey, input logic en);
    chk1({tag, "_done"}, done, 1'b1);
    chk1({tag, "_busy_off"}, busy, 1'b0);
    chk6({tag, "_y"}, y, ey);
    chk1({tag, "_neg"}, neg, en);
`ifdef SERIAL_SUB_RANGE_EN
    chk1({tag, "_ovf"}, ovf, en | ey[5]);
`endif
    last_y   = ey;
    last_neg = en;
  endtask

  // One operation started from IDLE; returns at the negedge of the done cycle.
  task automatic do_op(input string tag, input logic [5:0] sv, input logic [4:0] xv,
                       input logic [5:0] ey, input logic en, input bit detail);
    @(negedge clk);
    s = sv; x = xv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = 6'($urandom); x = 5'($urandom);
    for (int i = 0; i < 6; i++) begin
      if (detail) begin
        chk1({tag, "_busy"}, busy, 1'b1);
        chk1({tag, "_nodone"}, done, 1'b0);
        chk6({tag, "_y_hold"}, y, last_y);
      end
      @(negedge clk);
    end
    chk_result(tag, ey, en);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_y   = 6'd0;
    last_neg = 1'b0;
    reset = 1'b1; start = 1'b0; s = 6'd0; x = 5'd0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk6("rst_y", y, 6'd0);
    chk1("rst_neg", neg, 1'b0);
`ifdef SERIAL_SUB_RANGE_EN
    chk1("rst_ovf", ovf, 1'b0);
`endif
    reset = 1'b0;

    do_op("s45x13", 6'd45, 5'd13, 6'd32, 1'b0, 1'b1);
    @(negedge clk);
    chk1("after_done_pulse", done, 1'b0);
    do_op("s20x20", 6'd20, 5'd20, 6'd0,  1'b0, 1'b1);
    do_op("s63x0",  6'd63, 5'd0,  6'd63, 1'b0, 1'b1);
    do_op("s62x31", 6'd62, 5'd31, 6'd31, 1'b0, 1'b1);
    do_op("s5x9",   6'd5,  5'd9,  6'd60, 1'b1, 1'b1);

    // start pulsed during SHIFT is ignored
    @(negedge clk);
    s = 6'd10; x = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    s = 6'd50; x = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("ign_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    chk_result("ign", 6'd7, 1'b0);
    @(negedge clk);
    chk1("ign_no_restart_busy", busy, 1'b0);
    chk1("ign_no_restart_done", done, 1'b0);

    // start held high through DONE launches the next operation immediately
    s = 6'd40; x = 5'd8; start = 1'b1;
    repeat (6) @(negedge clk);
    s = 6'd12; x = 5'd20;
    @(negedge clk);
    chk_result("b2b_first", 6'd32, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk1("b2b_busy", busy, 1'b1);
      chk1("b2b_nodone", done, 1'b0);
      chk6("b2b_y_hold", y, 6'd32);
      @(negedge clk);
    end
    chk_result("b2b_second", 6'd56, 1'b1);

    // reset in the 4th SHIFT cycle aborts the operation
    @(negedge clk);
    s = 6'd30; x = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk6("abort_y", y, 6'd0);
    chk1("abort_neg", neg, 1'b0);
`ifdef SERIAL_SUB_RANGE_EN
    chk1("abort_ovf", ovf, 1'b0);
`endif
    last_y = 6'd0;
    begin
      logic seen_done;
      seen_done = 1'b0;
      repeat (10) begin
        @(negedge clk);
        seen_done = seen_done | done | busy;
      end
      chk1("abort_no_done", seen_done, 1'b0);
    end

    // Recover every 5-bit addend a from s = a + b, x = b
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        do_op("exh", 6'(a + b), 5'(b), 6'(a), 1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
